// File: rtl/counter_nbit_updown.sv
// rtl/counter_nbit_updown.sv - parametrised up/down counter with load, terminal, wrap pulse and sticky overflow
// Define COUNTER_SATURATE_EN to saturate at the boundaries instead of wrapping.
module counter_nbit_updown #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap,
  output logic             ovf_sticky
);

  // WIDTH+1 bits so MODULUS = 2**WIDTH is representable
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MODULUS - 1);

  logic [WIDTH:0]   inc_ext;
  logic [WIDTH-1:0] dec_val;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_evt;

  assign inc_ext  = {1'b0, count} + (WIDTH + 1)'(1);
  assign dec_val  = count - WIDTH'(1);
  assign at_top   = (inc_ext == MOD_EXT);
  assign at_bot   = (count == '0);
  assign terminal = enable & ((up_down & at_top) | (~up_down & at_bot));

  always_comb begin
    count_nxt = count;
    wrap_evt  = 1'b0;
    if (set) begin
      count_nxt = MAX_EXT[WIDTH-1:0];
    end else if (load) begin
      if ({1'b0, load_value} >= MOD_EXT)
        count_nxt = MAX_EXT[WIDTH-1:0];
      else
        count_nxt = load_value;
    end else if (enable) begin
      if (terminal) begin
        wrap_evt = 1'b1;
`ifdef COUNTER_SATURATE_EN
        count_nxt = count;
`else
        count_nxt = up_down ? '0 : MAX_EXT[WIDTH-1:0];
`endif
      end else begin
        count_nxt = up_down ? inc_ext[WIDTH-1:0] : dec_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      wrap       <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_evt;
      // a wrap event on the same edge overrides clear_ovf
      if (wrap_evt)
        ovf_sticky <= 1'b1;
      else if (clear_ovf)
        ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_nbit_updown.sv
// tb/tb_counter_nbit_updown.sv - randomized self-checking bench for counter_nbit_updown (WIDTH=4, MODULUS=10)
module tb_counter_nbit_updown;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset, set, load, enable, up_down, clear_ovf;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         terminal, wrap, ovf_sticky;

  int checks   = 0;
  int failures = 0;

  int m_count = 0;
  int m_wrap  = 0;
  int m_ovf   = 0;
  int wrap_seen;

  counter_nbit_updown #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .reset(reset), .set(set), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .clear_ovf(clear_ovf),
    .count(count), .terminal(terminal), .wrap(wrap), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wrap  = 0;
    m_ovf   = 0;
  endtask

  // Reference behaviour written from the counting rules with plain modular arithmetic
  task automatic model_step(input int s, input int l, input int lv, input int e,
                            input int ud, input int co);
    int boundary;
    m_wrap = 0;
    if (s != 0) begin
      m_count = M - 1;
    end else if (l != 0) begin
      m_count = (lv >= M) ? M - 1 : lv;
    end else if (e != 0) begin
      boundary = ud != 0 ? (m_count == M - 1) : (m_count == 0);
      if (boundary != 0) m_wrap = 1;
`ifdef COUNTER_SATURATE_EN
      if (boundary == 0) m_count = ud != 0 ? m_count + 1 : m_count - 1;
`else
      m_count = ud != 0 ? (m_count + 1) % M : (m_count + M - 1) % M;
`endif
    end
    if (m_wrap != 0) m_ovf = 1;
    else if (co != 0) m_ovf = 0;
  endtask

  task automatic cyc(input string tag, input int s, input int l, input int lv,
                     input int e, input int ud, input int co);
    set = s[0]; load = l[0]; load_value = lv[W-1:0];
    enable = e[0]; up_down = ud[0]; clear_ovf = co[0];
    #1;
    check({tag, ".terminal"}, terminal,
          (e != 0 && ((ud != 0 && m_count == M - 1) || (ud == 0 && m_count == 0))) ? 1 : 0);
    @(posedge clk);
    model_step(s, l, lv, e, ud, co);
    #1;
    check({tag, ".count"}, count, m_count);
    check({tag, ".wrap"}, wrap, m_wrap);
    check({tag, ".ovf"}, ovf_sticky, m_ovf);
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic async_reset_pulse(input string tag);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check({tag, ".count"}, count, 0);
    check({tag, ".wrap"}, wrap, 0);
    check({tag, ".ovf"}, ovf_sticky, 0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; set = 0; load = 0; load_value = '0;
    enable = 0; up_down = 1; clear_ovf = 0;
    #12;
    check("rst.count", count, 0);
    check("rst.wrap", wrap, 0);
    check("rst.ovf", ovf_sticky, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // count up 12 from 0: one wrap, sticky afterwards
    wrap_seen = 0;
    for (int i = 0; i < 12; i++) cyc("up", 0, 0, 0, 1, 1, 0);
    check("up.wrap_count", wrap_seen, 1);
    check("up.ovf_after", ovf_sticky, 1);

    // down from 0
    cyc("ld0", 0, 1, 0, 0, 1, 0);
    cyc("dn0", 0, 0, 0, 1, 0, 0);
`ifdef COUNTER_SATURATE_EN
    check("dn0.value", count, 0);
`else
    check("dn0.value", count, M - 1);
`endif
    check("dn0.pulse", wrap, 1);

    // load and clamp
    cyc("ld7", 0, 1, 7, 0, 1, 0);
    check("ld7.value", count, 7);
    cyc("ld13", 0, 1, 13, 0, 1, 0);
    check("ld13.clamp", count, M - 1);
    check("ld13.nowrap", wrap, 0);

    // set beats load, then wrap up
    cyc("setld", 1, 1, 3, 1, 1, 0);
    check("setld.value", count, M - 1);
    cyc("setwr", 0, 0, 0, 1, 1, 0);
    check("setwr.pulse", wrap, 1);

    // wrap event coincident with clear_ovf, then clear alone
    cyc("clr.pre", 1, 0, 0, 0, 1, 0);
    cyc("clr.evt", 0, 0, 0, 1, 1, 1);
    check("clr.evt.sticky", ovf_sticky, 1);
    cyc("clr.only", 0, 0, 0, 0, 1, 1);
    check("clr.only.sticky", ovf_sticky, 0);

    // async reset mid-count at count=6 with ovf set
    cyc("pre6.wrap", 1, 0, 0, 0, 1, 0);
    cyc("pre6.wrap2", 0, 0, 0, 1, 1, 0);
    cyc("pre6.ld", 0, 1, 6, 0, 1, 0);
    check("pre6.value", count, 6);
    async_reset_pulse("midrst");
    cyc("post_rst", 0, 0, 0, 1, 1, 0);
    check("post_rst.value", count, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset_pulse("rnd.rst");
      end else begin
        cyc("rnd",
            ($urandom_range(0, 19) == 0) ? 1 : 0,
            ($urandom_range(0, 9) == 0) ? 1 : 0,
            $urandom_range(0, 15),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 2) != 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
